id_ex_pipe: RTL and testbench

- Pipeline register between the decode/hazard stage and the execute stage of the 16-bit MIPS core.
- Each cycle it captures the decoded instruction fields and resolves operand forwarding using the 2-bit forward selects from the hazard unit.
- It inserts a bubble on a hazard stall or a branch flush, holds state on a pipeline freeze (cache miss), and keeps a saturating count of inserted bubbles.

---
 rtl/id_ex_pipe.sv | 150 +++++++++++++++
 tb/tb_id_ex_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the 16-bit MIPS core.
// Captures decoded fields, resolves operand forwarding at the edge,
// inserts bubbles on stall/flush, holds on freeze, and counts bubbles.
module id_ex_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int OPC_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              stall,
    input  logic [1:0]        forward_A,
    input  logic [1:0]        forward_B,
    input  logic [OPC_W-1:0]  opc_id,
    input  logic [REG_W-1:0]  rs1_id,
    input  logic [REG_W-1:0]  rs2_id,
    input  logic [REG_W-1:0]  rd_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [OPC_W-1:0]  opc_ex,
    output logic [REG_W-1:0]  rs1_ex,
    output logic [REG_W-1:0]  rs2_ex,
    output logic [REG_W-1:0]  rd_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [DATA_W-1:0] op_a_ex,
    output logic [DATA_W-1:0] op_b_ex,
    output logic              valid_ex,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [OPC_W-1:0]  opc_d,   opc_q;
    logic [REG_W-1:0]  rs1_d,   rs1_q;
    logic [REG_W-1:0]  rs2_d,   rs2_q;
    logic [REG_W-1:0]  rd_d,    rd_q;
    logic [DATA_W-1:0] imm_d,   imm_q;
    logic [DATA_W-1:0] op_a_d,  op_a_q;
    logic [DATA_W-1:0] op_b_d,  op_b_q;
    logic              valid_d, valid_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;

    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;

    // Forwarding mux for operand A: regfile / EX / MEM / WB.
    always_comb begin
        fwd_a_s = rdata1;
        case (forward_A)
            2'b00:   fwd_a_s = rdata1;
            2'b01:   fwd_a_s = ex_result;
            2'b10:   fwd_a_s = mem_result;
            2'b11:   fwd_a_s = wb_result;
            default: fwd_a_s = rdata1;
        endcase
    end

    // Forwarding mux for operand B, same encoding as A.
    always_comb begin
        fwd_b_s = rdata2;
        case (forward_B)
            2'b00:   fwd_b_s = rdata2;
            2'b01:   fwd_b_s = ex_result;
            2'b10:   fwd_b_s = mem_result;
            2'b11:   fwd_b_s = wb_result;
            default: fwd_b_s = rdata2;
        endcase
    end

    // Next-state selection: freeze holds, flush/stall insert one bubble, else load.
    always_comb begin
        opc_d   = opc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (freeze) begin
            cnt_d = cnt_q;
        end else if (flush || stall) begin
            // Both asserted together still count as a single bubble.
            opc_d   = {OPC_W{1'b0}};
            rs1_d   = {REG_W{1'b0}};
            rs2_d   = {REG_W{1'b0}};
            rd_d    = {REG_W{1'b0}};
            imm_d   = {DATA_W{1'b0}};
            op_a_d  = {DATA_W{1'b0}};
            op_b_d  = {DATA_W{1'b0}};
            valid_d = 1'b0;
            if (&cnt_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            opc_d   = opc_id;
            rs1_d   = rs1_id;
            rs2_d   = rs2_id;
            rd_d    = rd_id;
            imm_d   = imm_id;
            op_a_d  = fwd_a_s;
            op_b_d  = fwd_b_s;
            valid_d = 1'b1;
        end
    end

    // Pipeline state; reset leaves a NOP bubble with a cleared counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opc_q   <= {OPC_W{1'b0}};
            rs1_q   <= {REG_W{1'b0}};
            rs2_q   <= {REG_W{1'b0}};
            rd_q    <= {REG_W{1'b0}};
            imm_q   <= {DATA_W{1'b0}};
            op_a_q  <= {DATA_W{1'b0}};
            op_b_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            opc_q   <= opc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign opc_ex       = opc_q;
    assign rs1_ex       = rs1_q;
    assign rs2_ex       = rs2_q;
    assign rd_ex        = rd_q;
    assign imm_ex       = imm_q;
    assign op_a_ex      = op_a_q;
    assign op_b_ex      = op_b_q;
    assign valid_ex     = valid_q;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe.
// A second instance with a 4-bit counter exercises saturation quickly.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, stall;
    logic        s_stall;
    logic [1:0]  forward_A, forward_B;
    logic [3:0]  opc_id;
    logic [2:0]  rs1_id, rs2_id, rd_id;
    logic [15:0] imm_id, rdata1, rdata2, ex_result, mem_result, wb_result;

    logic [3:0]  opc_ex;
    logic [2:0]  rs1_ex, rs2_ex, rd_ex;
    logic [15:0] imm_ex, op_a_ex, op_b_ex;
    logic        valid_ex;
    logic [15:0] bubble_count;

    logic [3:0]  s_opc_ex;
    logic [2:0]  s_rs1_ex, s_rs2_ex, s_rd_ex;
    logic [15:0] s_imm_ex, s_op_a_ex, s_op_b_ex;
    logic        s_valid_ex;
    logic [3:0]  s_bubble_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .stall(stall),
        .forward_A(forward_A), .forward_B(forward_B),
        .opc_id(opc_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .imm_id(imm_id), .rdata1(rdata1), .rdata2(rdata2),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .opc_ex(opc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .imm_ex(imm_ex), .op_a_ex(op_a_ex), .op_b_ex(op_b_ex),
        .valid_ex(valid_ex), .bubble_count(bubble_count)
    );

    id_ex_pipe #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .freeze(1'b0), .flush(1'b0), .stall(s_stall),
        .forward_A(forward_A), .forward_B(forward_B),
        .opc_id(opc_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .imm_id(imm_id), .rdata1(rdata1), .rdata2(rdata2),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .opc_ex(s_opc_ex), .rs1_ex(s_rs1_ex), .rs2_ex(s_rs2_ex), .rd_ex(s_rd_ex),
        .imm_ex(s_imm_ex), .op_a_ex(s_op_a_ex), .op_b_ex(s_op_b_ex),
        .valid_ex(s_valid_ex), .bubble_count(s_bubble_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; stall = 1'b0; s_stall = 1'b0;
        forward_A = 2'b00; forward_B = 2'b00;
        opc_id = 4'h0; rs1_id = 3'd0; rs2_id = 3'd0; rd_id = 3'd0;
        imm_id = 16'h0; rdata1 = 16'h0; rdata2 = 16'h0;
        ex_result = 16'h0; mem_result = 16'h0; wb_result = 16'h0;
        #3;
        check_val("rst_opc",   {28'd0, opc_ex}, 32'h0);
        check_val("rst_valid", {31'd0, valid_ex}, 32'h0);
        check_val("rst_cnt",   {16'd0, bubble_count}, 32'h0);
        step();
        rst = 1'b0;

        // first load after reset, with all fields
        opc_id = 4'h1; rs1_id = 3'd2; rs2_id = 3'd3; rd_id = 3'd4;
        imm_id = 16'hFFF0; rdata1 = 16'h1234; rdata2 = 16'h0BBB;
        step();
        check_val("load_opa",   {16'd0, op_a_ex}, 32'h1234);
        check_val("load_fields", {17'd0, rs1_ex, rs2_ex, rd_ex, opc_ex},
                  {17'd0, 3'd2, 3'd3, 3'd4, 4'h1});
        check_val("load_imm",   {16'd0, imm_ex}, 32'hFFF0);
        check_val("load_opb",   {16'd0, op_b_ex}, 32'h0BBB);
        check_val("load_valid", {31'd0, valid_ex}, 32'h1);

        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1;
        check_val("arst_opa",   {16'd0, op_a_ex}, 32'h0);
        check_val("arst_opc",   {28'd0, opc_ex}, 32'h0);
        check_val("arst_valid", {31'd0, valid_ex}, 32'h0);
        #1 rst = 1'b0;
        opc_id = 4'h1; rdata1 = 16'h00AA;
        step();
        check_val("post_rst_opc", {28'd0, opc_ex}, 32'h1);
        check_val("post_rst_opa", {16'd0, op_a_ex}, 32'h00AA);

        // forwarding sweep on both operands
        rdata1 = 16'h1111; rdata2 = 16'h5555;
        ex_result = 16'h2222; mem_result = 16'h3333; wb_result = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_a;
            logic [15:0] exp_b;
            forward_A = i[1:0];
            forward_B = i[1:0];
            exp_a = (i == 0) ? 16'h1111 : (i == 1) ? 16'h2222 : (i == 2) ? 16'h3333 : 16'h4444;
            exp_b = (i == 0) ? 16'h5555 : exp_a;
            step();
            check_val($sformatf("fwd_a_%0d", i), {16'd0, op_a_ex}, {16'd0, exp_a});
            check_val($sformatf("fwd_b_%0d", i), {16'd0, op_b_ex}, {16'd0, exp_b});
        end
        forward_A = 2'b00; forward_B = 2'b00;
        check_val("cnt_after_loads", {16'd0, bubble_count}, 32'h0);

        // stall for two cycles
        opc_id = 4'hA; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val($sformatf("stall_opc_%0d", i), {28'd0, opc_ex}, 32'h0);
            check_val($sformatf("stall_valid_%0d", i), {31'd0, valid_ex}, 32'h0);
            check_val($sformatf("stall_opa_%0d", i), {16'd0, op_a_ex}, 32'h0);
        end
        check_val("stall_cnt", {16'd0, bubble_count}, 32'h2);
        stall = 1'b0;
        step();
        check_val("unstall_opc",   {28'd0, opc_ex}, 32'hA);
        check_val("unstall_valid", {31'd0, valid_ex}, 32'h1);

        // freeze dominates flush and stall
        freeze = 1'b1; flush = 1'b1; stall = 1'b1; opc_id = 4'h5; rdata1 = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("frz_opc_%0d", i), {28'd0, opc_ex}, 32'hA);
            check_val($sformatf("frz_valid_%0d", i), {31'd0, valid_ex}, 32'h1);
            check_val($sformatf("frz_opa_%0d", i), {16'd0, op_a_ex}, 32'h1111);
            check_val($sformatf("frz_cnt_%0d", i), {16'd0, bubble_count}, 32'h2);
        end
        freeze = 1'b0; stall = 1'b0;
        step();
        check_val("unfrz_flush_valid", {31'd0, valid_ex}, 32'h0);
        check_val("unfrz_flush_opc",   {28'd0, opc_ex}, 32'h0);
        check_val("unfrz_flush_cnt",   {16'd0, bubble_count}, 32'h3);

        // flush and stall together count once
        flush = 1'b0;
        step();
        check_val("reload_opc", {28'd0, opc_ex}, 32'h5);
        check_val("reload_opa", {16'd0, op_a_ex}, 32'h7777);
        flush = 1'b1; stall = 1'b1;
        step();
        check_val("fl_st_valid", {31'd0, valid_ex}, 32'h0);
        check_val("fl_st_cnt",   {16'd0, bubble_count}, 32'h4);
        flush = 1'b0; stall = 1'b0;
        step();
        check_val("fl_st_after_cnt", {16'd0, bubble_count}, 32'h4);

        // saturation on the 4-bit counter instance
        check_val("sat_start", {28'd0, s_bubble_count}, 32'h0);
        s_stall = 1'b1;
        for (int i = 0; i < 14; i++) step();
        check_val("sat_pre", {28'd0, s_bubble_count}, 32'hE);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("sat_%0d", i), {28'd0, s_bubble_count}, 32'hF);
        end
        s_stall = 1'b0;
        step();
        check_val("sat_hold", {28'd0, s_bubble_count}, 32'hF);
        check_val("sat_main_cnt", {16'd0, bubble_count}, 32'h4);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
